// File: rtl/shift_pkg.sv
// Shared definitions for the shift command FIFO and its combinational core.
package shift_pkg;

  localparam logic [1:0] MODE_SHL  = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_ROTL = 2'b10;
  localparam logic [1:0] MODE_ROTR = 2'b11;

  localparam int CMD_N       = 4;
  localparam int CMD_SHIFT_W = $clog2(CMD_N);

  typedef struct packed {
    logic [CMD_N-1:0]       data;
    logic [CMD_SHIFT_W-1:0] shift;
    logic [1:0]             mode;
  } cmd_t;

endpackage

// File: rtl/rot_shift_core.sv
// Combinational 4-mode shifter: logical shifts and rotates by a variable amount.
module rot_shift_core
  import shift_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         data,
  input  logic [$clog2(N)-1:0] shift,
  input  logic [1:0]           mode,
  output logic [N-1:0]         out
);

  localparam int SW = $clog2(N);

  // One extra bit so that N itself is representable when shift is zero.
  logic [SW:0] inv_shift;
  assign inv_shift = (SW+1)'(N) - {1'b0, shift};

  always_comb begin
    out = data;
    case (mode)
      MODE_SHL:  out = data << shift;
      MODE_SHR:  out = data >> shift;
      MODE_ROTL: out = (shift == '0) ? data : ((data << shift) | (data >> inv_shift));
      MODE_ROTR: out = (shift == '0) ? data : ((data >> shift) | (data << inv_shift));
      default:   out = data;
    endcase
  end

endmodule

// File: rtl/shift_cmd_fifo.sv
// Handshaked command FIFO in front of rot_shift_core with a registered result stage.
module shift_cmd_fifo
  import shift_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_data,
  input  logic [$clog2(N)-1:0]       in_shift,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_data,
  output logic [1:0]                 out_mode,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int SW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [N-1:0]  data;
    logic [SW-1:0] shift;
    logic [1:0]    mode;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  entry_t        head;
  logic [N-1:0]  core_out;

  // Readiness comes only from the registered count; no pass-through when full.
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  rot_shift_core #(.N(N)) u_core (
    .data  (head.data),
    .shift (head.shift),
    .mode  (head.mode),
    .out   (core_out)
  );

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= '{data: in_data, shift: in_shift, mode: in_mode};
    end
  end

  // Flush outranks any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= '0;
    end else if (flush) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= core_out;
        out_mode  <= head.mode;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_cmd_fifo.sv
// Self-checking bench for shift_cmd_fifo: directed latency/boundary checks plus an order scoreboard.
module tb_shift_cmd_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [1:0] in_shift;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_mode;
  logic [2:0] count;

  int checkCount  = 0;
  int passCount   = 0;
  int resultCount = 0;
  logic [5:0] sb [$];
  bit pushDone;

  shift_cmd_fifo #(.N(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Reference shifter built from single-bit steps, independent of the RTL formulation.
  function automatic logic [3:0] model(input logic [3:0] d, input logic [1:0] s, input logic [1:0] m);
    logic [3:0] r;
    r = d;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(s)) begin
        case (m)
          2'b00:   r = {r[2:0], 1'b0};
          2'b01:   r = {1'b0, r[3:1]};
          2'b10:   r = {r[2:0], r[3]};
          default: r = {r[0], r[3:1]};
        endcase
      end
    end
    return r;
  endfunction

  // Accepted commands feed the scoreboard; handshaken results are popped and compared.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_result", 1, 0);
        end else begin
          logic [5:0] e;
          e = sb.pop_front();
          checkOutput("sb_data", out_data, e[5:2]);
          checkOutput("sb_mode", out_mode, e[1:0]);
          resultCount++;
        end
      end
      if (in_valid && in_ready) sb.push_back({model(in_data, in_shift, in_mode), in_mode});
    end
  end

  task automatic applyStimulus(input logic [3:0] d, input logic [1:0] s, input logic [1:0] m);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_shift = s;
    in_mode  = m;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) checkOutput("push_timeout", 0, 1);
  endtask

  task automatic directedShift(input logic [3:0] d, input logic [1:0] s, input logic [1:0] m,
                               input logic [3:0] expected);
    applyStimulus(d, s, m);
    checkOutput("lat_count_after_push", count, 1);
    checkOutput("lat_no_bypass", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("lat_valid", out_valid, 1);
    checkOutput("lat_data", out_data, expected);
    checkOutput("lat_mode", out_mode, m);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rc0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_mode = '0;
    out_ready = 1'b1;
    #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_mode", out_mode, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] basic modes");
    directedShift(4'b1011, 2'd1, 2'b00, 4'b0110);
    directedShift(4'b1011, 2'd1, 2'b01, 4'b0101);
    directedShift(4'b1011, 2'd1, 2'b10, 4'b0111);
    directedShift(4'b1011, 2'd1, 2'b11, 4'b1101);

    $display("[TB] zero and maximum shift");
    directedShift(4'b1001, 2'd0, 2'b10, 4'b1001);
    directedShift(4'b1001, 2'd0, 2'b11, 4'b1001);
    directedShift(4'b1111, 2'd3, 2'b00, 4'b1000);
    directedShift(4'b1111, 2'd3, 2'b01, 4'b0001);

    $display("[TB] backpressure and full");
    rc0 = resultCount;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(4'(i + 3), 2'(i), 2'(i));
    in_valid = 1'b1; in_data = 4'b1100; in_shift = 2'd2; in_mode = 2'b11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("full_count", count, 4);
    checkOutput("full_in_ready", in_ready, 0);
    checkOutput("full_out_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_pop", in_ready, 1);
    checkOutput("count_after_pop", count, 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("drain_results", resultCount - rc0, 6);
    checkOutput("drain_sb_empty", sb.size(), 0);

    $display("[TB] stall stability");
    out_ready = 1'b0;
    applyStimulus(4'b1011, 2'd2, 2'b10);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_data", out_data, 4'b1110);
      checkOutput("stall_mode", out_mode, 2'b10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] random order across pointer wrap");
    rc0 = resultCount;
    pushDone = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          applyStimulus(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        pushDone = 1'b1;
      end
      begin
        for (int i = 0; i < 2000 && !pushDone; i++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("rand_results", resultCount - rc0, 20);
    checkOutput("rand_sb_empty", sb.size(), 0);

    $display("[TB] flush");
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(4'(9 + i), 2'd1, 2'b00);
    checkOutput("preflush_count", count, 3);
    checkOutput("preflush_valid", out_valid, 1);
    in_valid = 1'b1; in_data = 4'b0101; in_shift = 2'd1; in_mode = 2'b10;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_count", count, 0);
    checkOutput("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush_push_dropped", out_valid, 0);
    directedShift(4'b0110, 2'd1, 2'b11, 4'b0011);

    $display("[TB] asynchronous reset");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(4'(5 + i), 2'd2, 2'b01);
    checkOutput("prereset_count", count, 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_count", count, 0);
    checkOutput("async_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    directedShift(4'b0011, 2'd3, 2'b10, 4'b1001);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
